mul_add_arbiter: RTL

//   Round-robin arbiter sharing one multiply-add unit (multiplication_c: out = a*b + c, registered) between
//   N_REQ requesters. Accepts one operand set per cycle via valid/ready, registers it onto the unit's inputs,

---
 rtl/mul_add_arbiter_if.sv | 53 +++++
 rtl/mul_add_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_add_arbiter_if
//   Bundles every non-clock signal of the mul_add_arbiter into one interface.
//   The slave modport is the arbiter's view. The master modport is the
//   environment's view: the requesters, the software flush control and the
//   shared multiply-add unit that drives mul_out.
//
//   req_valid  N_REQ      per-requester operand valid
//   req_a/b/c  N_REQ*W    operands, requester i at [i*W +: W]
//   req_ready  N_REQ      one-hot combinational grant
//   flush      1          stop granting and drain in-flight ops
//   mul_a/b/c  W          registered operands toward the shared unit
//   mul_out    OUT_W      result coming back from the shared unit
//   resp_valid 1          one-cycle response strobe
//   resp_id    ID_W       requester index of the response
//   resp_data  OUT_W      a*b + c of the response
//   busy       1          ops in flight or draining
//   issued_cnt 16         wrapping count of accepted transfers
// ---------------------------------------------------------------------------
interface mul_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int OUT_W = 2*W+1,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*W-1:0] req_c;
  logic [N_REQ-1:0]   req_ready;
  logic               flush;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic [W-1:0]       mul_c;
  logic [OUT_W-1:0]   mul_out;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [OUT_W-1:0]   resp_data;
  logic               busy;
  logic [15:0]        issued_cnt;

  modport master (
    output req_valid, req_a, req_b, req_c, flush, mul_out,
    input  req_ready, mul_a, mul_b, mul_c, resp_valid, resp_id, resp_data,
           busy, issued_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, flush, mul_out,
    output req_ready, mul_a, mul_b, mul_c, resp_valid, resp_id, resp_data,
           busy, issued_cnt
  );
endinterface

// File: rtl/mul_add_arbiter.sv
// ---------------------------------------------------------------------------
// mul_add_arbiter
//   Round-robin arbiter in front of one shared, registered multiply-add unit
//   (out = a*b + c). One operand set is accepted per cycle, registered onto
//   the unit inputs, and its requester ID travels down a parallel ID pipeline
//   so the result comes back tagged with the ID. A RUN/DRAIN FSM lets
//   software stop new grants and wait for the unit to go idle.
//
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mul_add_arbiter_if.slave (requests, grants, unit I/O, responses,
//         flush, busy, issued_cnt)
// ---------------------------------------------------------------------------
module mul_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int LATENCY = 1,
  parameter int OUT_W   = 2*W+1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  mul_add_arbiter_if.slave bus
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [LATENCY:0]           pipe_vld_q, pipe_vld_d;
  logic [LATENCY:0][ID_W-1:0] pipe_id_q, pipe_id_d;
  logic [W-1:0]               mul_a_q, mul_a_d;
  logic [W-1:0]               mul_b_q, mul_b_d;
  logic [W-1:0]               mul_c_q, mul_c_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]            resp_id_q, resp_id_d;
  logic [OUT_W-1:0]           resp_data_q, resp_data_d;
  logic [15:0]                issued_cnt_q, issued_cnt_d;

  logic            grant_en;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            xfer;
  logic            pipe_empty;

  logic [W-1:0] op_a [N_REQ];
  logic [W-1:0] op_b [N_REQ];
  logic [W-1:0] op_c [N_REQ];

  // Unpack the flat operand buses so the granted index can select directly.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a[i] = bus.req_a[i*W +: W];
    assign op_b[i] = bus.req_b[i*W +: W];
    assign op_c[i] = bus.req_c[i*W +: W];
  end

  // Round-robin search starting at ptr; only req_valid and ptr feed it, so
  // the grant can never loop back through req_ready.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign pipe_empty = (pipe_vld_q == '0);
  assign xfer       = grant_en && grant_found;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: leave DRAIN only once nothing is in flight and software
  // has released flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush) state_d = DRAIN;
      DRAIN:   if (pipe_empty && !bus.flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: flush kills the grant in the same cycle it is raised.
  always_comb begin
    grant_en      = (state_q == RUN) && !bus.flush;
    bus.req_ready = '0;
    if (grant_en && grant_found) bus.req_ready[grant_idx] = 1'b1;
    bus.busy      = !pipe_empty || (state_q == DRAIN);
  end

  // Datapath next-state: operand capture, ID pipeline shift, response
  // capture, pointer and issue counter.
  always_comb begin
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_c_d      = mul_c_q;
    ptr_d        = ptr_q;
    issued_cnt_d = issued_cnt_q;
    pipe_vld_d   = '0;
    pipe_id_d    = '0;
    resp_valid_d = pipe_vld_q[LATENCY];
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;

    if (xfer) begin
      mul_a_d      = op_a[grant_idx];
      mul_b_d      = op_b[grant_idx];
      mul_c_d      = op_c[grant_idx];
      ptr_d        = ID_W'((int'(grant_idx) + 1) % N_REQ);
      issued_cnt_d = issued_cnt_q + 16'd1;
    end else if (state_q == DRAIN && state_d == RUN) begin
      ptr_d = '0;
    end

    // Stage 0 holds the op just registered onto the unit; stage LATENCY
    // lines up with the cycle its result is present on mul_out.
    pipe_vld_d[0] = xfer;
    pipe_id_d[0]  = xfer ? grant_idx : '0;
    for (int s = 1; s <= LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_id_d[s]  = pipe_id_q[s-1];
    end

    if (pipe_vld_q[LATENCY]) begin
      resp_id_d   = pipe_id_q[LATENCY];
      resp_data_d = bus.mul_out;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_c_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      issued_cnt_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_c_q      <= mul_c_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_c      = mul_c_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.issued_cnt = issued_cnt_q;

endmodule
